// File: rtl/execute_stage.sv
// execute_stage: RV32I execute stage with D/X register, MX/WX bypass, immediate decode, ALU and branch resolution
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_d,
  input  logic [31:0] inst_d,
  input  logic [31:0] rs1_d,
  input  logic [31:0] rs2_d,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  A_bypass,
  input  logic [1:0]  B_bypass,
  input  logic [31:0] alu_m,
  input  logic [31:0] wb_w,
  output logic [31:0] PC_x,
  output logic [31:0] inst_x,
  output logic [31:0] alu_x,
  output logic [31:0] rs2_x,
  output logic        br_taken,
  output logic [31:0] br_target
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] pc_e, inst_e, rs1_e, rs2_e;
  logic [31:0] op_a, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        lt, ltu;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_e   <= '0;
      inst_e <= NOP;
      rs1_e  <= '0;
      rs2_e  <= '0;
    end else if (flush) begin
      pc_e   <= '0;
      inst_e <= NOP;
      rs1_e  <= '0;
      rs2_e  <= '0;
    end else if (!stall) begin
      pc_e   <= PC_d;
      inst_e <= inst_d;
      rs1_e  <= rs1_d;
      rs2_e  <= rs2_d;
    end

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r, m, w);
    pick = sel == 2'b01 ? m : sel == 2'b10 ? w : r;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] f, input logic alt, input logic [31:0] a, b);
    case (f)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  assign op_a   = pick(A_bypass, rs1_e, alu_m, wb_w);
  assign rs2_x  = pick(B_bypass, rs2_e, alu_m, wb_w);
  assign opcode = inst_e[6:0];
  assign f3     = inst_e[14:12];
  assign imm_i  = {{20{inst_e[31]}}, inst_e[31:20]};
  assign imm_s  = {{20{inst_e[31]}}, inst_e[31:25], inst_e[11:7]};
  assign imm_b  = {{19{inst_e[31]}}, inst_e[31], inst_e[7], inst_e[30:25], inst_e[11:8], 1'b0};
  assign imm_u  = {inst_e[31:12], 12'b0};
  assign imm_j  = {{11{inst_e[31]}}, inst_e[31], inst_e[19:12], inst_e[20], inst_e[30:21], 1'b0};
  assign lt     = $signed(op_a) < $signed(rs2_x);
  assign ltu    = op_a < rs2_x;

  always_comb begin
    alu_x    = '0;
    br_taken = 1'b0;
    case (opcode)
      7'b0110111: alu_x = imm_u;
      7'b0010111: alu_x = pc_e + imm_u;
      7'b1101111: begin
        alu_x    = pc_e + imm_j;
        br_taken = 1'b1;
      end
      7'b1100111: begin
        alu_x    = (op_a + imm_i) & ~32'd1;
        br_taken = 1'b1;
      end
      7'b1100011: begin
        alu_x    = pc_e + imm_b;
        br_taken = f3 == 3'b000 ? op_a == rs2_x :
                   f3 == 3'b001 ? op_a != rs2_x :
                   f3 == 3'b100 ? lt  : f3 == 3'b101 ? !lt :
                   f3 == 3'b110 ? ltu : f3 == 3'b111 ? !ltu : 1'b0;
      end
      7'b0000011: alu_x = op_a + imm_i;
      7'b0100011: alu_x = op_a + imm_s;
      // only shifts honour funct7[5] for immediates; ADDI never subtracts
      7'b0010011: alu_x = alu(f3, inst_e[30] && f3 == 3'b101, op_a, imm_i);
      7'b0110011: alu_x = alu(f3, inst_e[30], op_a, rs2_x);
      default: ;
    endcase
  end

  assign PC_x      = pc_e;
  assign inst_x    = inst_e;
  assign br_target = alu_x;
endmodule

// File: doc/execute_stage.md
# execute_stage

Pipeline execute stage of the five-stage RV32I core, sitting between decode and `mem_stage`. It owns the D/X pipeline register with stall and flush control. It applies the MX/WX operand bypasses, decodes immediates, and computes the ALU result and branch resolution. It drives `PC_x`, `inst_x`, `alu_x` and `rs2_x`, which `mem_stage` registers on the next rising edge.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears the D/X register immediately.
- `PC_d` in 32: PC of the instruction in decode.
- `inst_d` in 32: instruction word in decode.
- `rs1_d` in 32: register-file read data for rs1.
- `rs2_d` in 32: register-file read data for rs2.
- `stall` in 1: hold the D/X register contents.
- `flush` in 1: load a bubble (NOP) into the D/X register.
- `A_bypass` in 2: operand A source. 00 = register, 01 = `alu_m`, 10 = `wb_w`, 11 = register.
- `B_bypass` in 2: operand B source, same encoding as `A_bypass`.
- `alu_m` in 32: ALU result currently held in the mem stage (MX path).
- `wb_w` in 32: writeback value currently in the writeback stage (WX path).
- `PC_x` out 32: PC of the instruction in execute.
- `inst_x` out 32: instruction in execute.
- `alu_x` out 32: ALU result.
- `rs2_x` out 32: bypassed rs2 value, used as store data.
- `br_taken` out 1: redirect fetch to `br_target`.
- `br_target` out 32: redirect address, equal to `alu_x` whenever `br_taken` = 1.

## Operation
- D/X register holds `PC_e`, `inst_e`, `rs1_e`, `rs2_e`. Update priority: reset > flush > stall > load.
  - Reset: `PC_e` = 0, `inst_e` = 0x00000013 (NOP), `rs1_e` = `rs2_e` = 0.
  - Flush: `inst_e` = NOP, `PC_e` = 0, data registers = 0.
  - Stall: all four registers hold.
  - Otherwise: load `PC_d`, `inst_d`, `rs1_d`, `rs2_d`.
- Operand muxes:
  - `opA` is `rs1_e`, `alu_m` or `wb_w` per `A_bypass`.
  - `rs2_x` is `rs2_e`, `alu_m` or `wb_w` per `B_bypass`.
- Immediates are decoded from `inst_e` in I, S, B, U and J format, all sign-extended to 32 bits.
- ALU by opcode. All arithmetic is 32-bit and wraps modulo 2^32.
  - LUI: U-immediate.
  - AUIPC: `PC_e` + U-immediate.
  - JAL: `PC_e` + J-immediate.
  - JALR: (`opA` + I-immediate) with bit 0 cleared.
  - BRANCH: `PC_e` + B-immediate.
  - LOAD: `opA` + I-immediate.
  - STORE: `opA` + S-immediate.
  - OP-IMM: funct3 operation on `opA` and I-immediate.
  - OP: funct3/funct7 operation on `opA` and `rs2_x`.
  - Unknown opcode: `alu_x` = 0 and `br_taken` = 0.
- Funct3 operations:
  - ADD/SUB: SUB only for OP with funct7[5] = 1.
  - SLL, SRL, SRA: shift amount is operand[4:0]; SRA is arithmetic.
  - SLT (signed), SLTU (unsigned).
  - XOR, OR, AND.
- Branch resolution:
  - JAL and JALR: `br_taken` = 1.
  - BRANCH: compare `opA` with `rs2_x`. BEQ/BNE use equality, BLT/BGE are signed, BLTU/BGEU are unsigned. funct3 010/011 is never taken.
  - All other opcodes: `br_taken` = 0.
- `inst_x` = `inst_e` and `PC_x` = `PC_e`.
- Flushing fetch and decode on `br_taken` is the responsibility of the hazard unit, not this block.

## Timing
- Latency: an instruction presented on the `_d` inputs at edge N appears on the `_x` outputs after edge N. `mem_stage` captures it at edge N+1.
- All outputs are combinational from the D/X register and the bypass inputs. There is no internal state beyond the D/X register.
- Bypass paths are combinational in the same cycle: a change on `alu_m` or `wb_w` propagates to `alu_x`, `rs2_x` and `br_taken` with no edge.
- Outputs during and after reset: `inst_x` = 0x00000013, `PC_x` = 0, `alu_x` = 0 (NOP computes x0 + 0), `rs2_x` = 0, `br_taken` = 0, `br_target` = 0.
- Reset asserted mid-stream clears the register without waiting for a clock edge. The first instruction is loaded on the first rising edge after deassertion.
- `stall` and `flush` asserted together: flush wins and a NOP is loaded.
- A stall of any length holds the outputs stable, apart from changes on the bypass inputs. Loading resumes on the first edge with `stall` = 0.

## Test plan
- Reset: assert `reset` between edges → all outputs take their reset values immediately. Release reset with `inst_d` = ADDI x1,x0,5 (0x00500093), then one edge → `alu_x` = 5, `br_taken` = 0.
- Bypass: load ADD x3,x1,x2 with `rs1_d` = 1, `rs2_d` = 2.
  - `A_bypass` = 01, `alu_m` = 10, `B_bypass` = 10, `wb_w` = 20 → `alu_x` = 30, `rs2_x` = 20.
  - Both selects = 11 → `alu_x` = 3.
- Arithmetic edges:
  - SUB 0 − 1 → 0xFFFFFFFF.
  - SRA of 0x80000000 by 31 → 0xFFFFFFFF.
  - SLT −1 < 1 → 1; SLTU of the same operands → 0.
  - SLLI by 0 → operand unchanged.
- Branches at `PC_d` = 0x100:
  - BLT −1,1 with B-immediate 8 → `br_taken` = 1, `br_target` = 0x108.
  - BLTU with the same operands → `br_taken` = 0.
  - JALR with rs1 = 0x203 and I-immediate 0 → `br_target` = 0x202.
- Stall and flush:
  - Hold `stall` for 3 edges while changing the `_d` inputs → `inst_x` unchanged.
  - Assert `stall` and `flush` together → `inst_x` = 0x00000013 and `br_taken` = 0 after the edge.
- Unknown opcode: `inst_d` = 0x0000007F → `alu_x` = 0, `br_taken` = 0.
